// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I datapath (shared ALU and shared memory).
// Latency: beq 3, R/I/sw/jal/lui 4, lw/jalr 5 cycles, plus one per memory wait cycle.
// Backpressure: FETCH, MEMREAD and MEMWR hold until MemReady; strobes only fire on the completing cycle.
module multicycle_control_unit #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        RegWrite,
  output logic        IllegalInstr
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_LUI, S_ALUWB, S_BEQ, S_JAL, S_JALRADR, S_JALRPC
  } state_t;

  state_t      state, next_state, cur;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, mem_rdy;
  logic        pc_update, branch, ir_write, mem_write, reg_write, illegal;
  logic [1:0]  alu_op;
  logic        unused_bits;

  assign opcode      = Instr[6:0];
  assign funct3      = Instr[14:12];
  assign funct7b5    = Instr[30];
  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign mem_rdy     = USE_MEM_READY ? MemReady : 1'b1;

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // While in reset the outputs show the FETCH decode (strobes are masked below).
  assign cur = rst_n ? state : S_FETCH;

  // Next-state selection: memory states hold until the access completes.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALRADR;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:  next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMREAD;
      S_MEMREAD: next_state = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_JAL,
      S_JALRPC:  next_state = S_ALUWB;
      S_JALRADR: next_state = S_JALRPC;
      default:   next_state = S_FETCH;
    endcase
  end

  // Per-state mux selects and raw strobes (Moore part, plus MemReady qualification).
  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
        ir_write = mem_rdy; pc_update = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        illegal = !(opcode inside {OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI});
      end
      S_MEMADR:  begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB:   begin ResultSrc = 2'b01; reg_write = 1'b1; end
      S_MEMWR:   begin AdrSrc = 1'b1; mem_write = mem_rdy; end
      S_EXECR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; alu_op = 2'b10; end
      S_EXECI:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op = 2'b10; end
      S_LUI:     begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      S_ALUWB:   reg_write = 1'b1;
      S_BEQ:     begin ALUSrcA = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      S_JAL,
      S_JALRPC:  begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
      S_JALRADR: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      default: ;
    endcase
  end

  // ALU operation decode; sub only for R-type with funct7 bit 5 set.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode == OP_R && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format is a pure function of the opcode.
  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Architectural strobes are suppressed for the whole reset cycle.
  assign PCWrite      = rst_n & (pc_update | (branch & Zero));
  assign IRWrite      = rst_n & ir_write;
  assign MemWrite     = rst_n & mem_write;
  assign RegWrite     = rst_n & reg_write;
  assign IllegalInstr = rst_n & illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed sequences with literal checks,
// then randomized instructions, memory stalls, Zero and resets against a step-plan model.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instr = 32'h0000_0033;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUControl, ImmSrc;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  multicycle_control_unit #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  // Steps an instruction walks through, as named in the datapath description.
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, XR = 6, XI = 7,
                 LU = 8, WB = 9, BQ = 10, JL = 11, JA = 12, JP = 13;

  int plan[$];

  localparam logic [31:0] SUB  = 32'h4000_0033;
  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] SW   = 32'h0000_2023;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] LUI  = 32'h0000_0037;
  localparam logic [31:0] ILL  = 32'h0000_007F;

  // Model: advance the step plan using the inputs present at the clock edge.
  task automatic advance();
    int cur;
    logic [6:0] op;
    if (!rst_n) begin
      plan.delete(); plan.push_back(F); plan.push_back(D);
      return;
    end
    cur = plan[0];
    op = Instr[6:0];
    if ((cur == F || cur == MR || cur == MW) && !MemReady) return;
    void'(plan.pop_front());
    if (cur == D) begin
      case (op)
        7'h03: begin plan.push_back(MA); plan.push_back(MR); plan.push_back(MWB); end
        7'h23: begin plan.push_back(MA); plan.push_back(MW); end
        7'h33: begin plan.push_back(XR); plan.push_back(WB); end
        7'h13: begin plan.push_back(XI); plan.push_back(WB); end
        7'h63: plan.push_back(BQ);
        7'h6F: begin plan.push_back(JL); plan.push_back(WB); end
        7'h67: begin plan.push_back(JA); plan.push_back(JP); plan.push_back(WB); end
        7'h37: begin plan.push_back(LU); plan.push_back(WB); end
        default: ;
      endcase
    end
    if (plan.size() == 0) begin plan.push_back(F); plan.push_back(D); end
  endtask

  function automatic logic [2:0] funct_alu(input logic [31:0] ins);
    case (ins[14:12])
      3'd0:    return (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // Expected output word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,A,B,ALU,Imm,RegWrite,Illegal}.
  function automatic logic [17:0] expect_out(input int st, input logic rst, input logic [31:0] ins,
                                             input logic z, input logic rdy);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, a = 0, b = 0;
    logic [2:0] alu = 0, imm;
    logic [6:0] op = ins[6:0];
    case (op)
      7'h23: imm = 3'd1;
      7'h63: imm = 3'd2;
      7'h6F: imm = 3'd3;
      7'h37: imm = 3'd4;
      default: imm = 3'd0;
    endcase
    if (!rst) st = F;
    case (st)
      F:   begin b = 2; rs = 2; irw = rdy; pcw = rdy; end
      D:   begin a = 1; b = 1;
             ill = !(op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 ||
                     op == 7'h63 || op == 7'h6F || op == 7'h67 || op == 7'h37); end
      MA:  begin a = 2; b = 1; end
      MR:  adr = 1;
      MWB: begin rs = 1; rw = 1; end
      MW:  begin adr = 1; mw = rdy; end
      XR:  begin a = 2; b = 0; alu = funct_alu(ins); end
      XI:  begin a = 2; b = 1; alu = funct_alu(ins); end
      LU:  begin a = 3; b = 1; end
      WB:  rw = 1;
      BQ:  begin a = 2; alu = 1; pcw = z; end
      JL, JP: begin a = 1; b = 2; pcw = 1; end
      JA:  begin a = 2; b = 1; end
      default: ;
    endcase
    if (!rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ill};
  endfunction

  // Single comparison point between the DUT and the model for the current cycle.
  task automatic check_model();
    logic [17:0] got, want;
    got  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, RegWrite, IllegalInstr};
    want = expect_out(plan[0], rst_n, Instr, Zero, MemReady);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL model cyc=%0d step=%0d instr=%h got=%b want=%b", cycle, plan[0], Instr, got, want);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cycle, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    cycle++;
    @(negedge clk);
  endtask

  task automatic apply(input logic r, input logic m, input logic z, input logic [31:0] ins);
    rst_n = r; MemReady = m; Zero = z; Instr = ins;
    #1;
    check_model();
  endtask

  task automatic cyc(input logic r, input logic m, input logic z, input logic [31:0] ins);
    tick();
    apply(r, m, z, ins);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] rr;
    logic [6:0]  ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    int k;
    rr = $urandom();
    k  = $urandom_range(0, 9);
    if (k < 8) return {rr[31:7], ops[k]};
    return rr;
  endfunction

  initial begin
    plan.push_back(F); plan.push_back(D);
    // Reset held two cycles
    cyc(0, 1, 0, SUB); lit("rst_irw", IRWrite, 0); lit("rst_pcw", PCWrite, 0);
    cyc(0, 1, 0, SUB); lit("rst_rw", RegWrite, 0); lit("rst_mw", MemWrite, 0);
    // sub
    cyc(1, 1, 0, SUB); lit("fetch_irw", IRWrite, 1); lit("fetch_b", ALUSrcB, 2);
    cyc(1, 1, 0, SUB); lit("dec_a", ALUSrcA, 1);
    cyc(1, 1, 0, SUB); lit("execr_alu", ALUControl, 1); lit("execr_a", ALUSrcA, 2);
                       lit("execr_b", ALUSrcB, 0);
    cyc(1, 1, 0, SUB); lit("aluwb_rw", RegWrite, 1); lit("aluwb_rs", ResultSrc, 0);
    // lw with two wait cycles: 7 cycles total
    cyc(1, 1, 0, LW);  lit("lw_fetch", IRWrite, 1);
    cyc(1, 1, 0, LW);
    cyc(1, 1, 0, LW);  lit("lw_memadr_a", ALUSrcA, 2);
    cyc(1, 0, 0, LW);  lit("lw_mr_adr", AdrSrc, 1);
    cyc(1, 0, 0, LW);  lit("lw_mr_hold", AdrSrc, 1); lit("lw_mr_rw", RegWrite, 0);
    cyc(1, 1, 0, LW);  lit("lw_mr_done", AdrSrc, 1);
    cyc(1, 1, 0, LW);  lit("lw_wb_rs", ResultSrc, 1); lit("lw_wb_rw", RegWrite, 1);
    cyc(1, 1, 0, BEQ); lit("lw_7cyc", IRWrite, 1);
    // beq not taken then taken
    cyc(1, 1, 0, BEQ);
    cyc(1, 1, 0, BEQ); lit("beq_nt_pcw", PCWrite, 0); lit("beq_alu", ALUControl, 1);
    cyc(1, 1, 1, BEQ); lit("beq_3cyc", IRWrite, 1);
    cyc(1, 1, 1, BEQ);
    cyc(1, 1, 1, BEQ); lit("beq_t_pcw", PCWrite, 1); lit("beq_t_alu", ALUControl, 1);
    // jal, lui
    cyc(1, 1, 0, JAL); lit("beq_t_3cyc", IRWrite, 1);
    cyc(1, 1, 0, JAL);
    cyc(1, 1, 0, JAL); lit("jal_pcw", PCWrite, 1); lit("jal_rs", ResultSrc, 0);
    cyc(1, 1, 0, JAL); lit("jal_wb_rw", RegWrite, 1);
    cyc(1, 1, 0, LUI);
    cyc(1, 1, 0, LUI);
    cyc(1, 1, 0, LUI); lit("lui_a", ALUSrcA, 3); lit("lui_imm", ImmSrc, 4);
    cyc(1, 1, 0, LUI); lit("lui_wb_rw", RegWrite, 1);
    // illegal opcode
    cyc(1, 1, 0, ILL);
    cyc(1, 1, 0, ILL); lit("ill_pulse", IllegalInstr, 1); lit("ill_rw", RegWrite, 0);
    cyc(1, 1, 0, SW);  lit("ill_end", IllegalInstr, 0); lit("ill_back", IRWrite, 1);
    // sw interrupted by reset while waiting in MEMWR
    cyc(1, 1, 0, SW);
    cyc(1, 1, 0, SW);
    cyc(1, 0, 0, SW);  lit("sw_wait_mw", MemWrite, 0); lit("sw_adr", AdrSrc, 1);
    cyc(0, 1, 0, SW);  lit("sw_rst_mw", MemWrite, 0);
    cyc(1, 1, 0, SW);  lit("sw_rst_fetch", IRWrite, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      tick();
      ins = Instr;
      if (plan[0] == F) ins = rand_instr();
      apply(($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) >= 3),
            logic'($urandom_range(0, 1)), ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
